// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows, synchronises columns, classifies each full
// scan as a single hit or nothing, and debounces press/release over whole scans.
module keypad_scanner #(
   parameter int TICK_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk0,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_down
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW:0]   CNT_DONE  = (CW + 1)'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   logic [3:0]    col_m_q, col_s_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    nkeys_q, nkeys_d;
   logic [3:0]    code_q, code_d;
   state_t        state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_down_q, key_down_d;

   logic          tick, scan_done, scan_hit;
   logic [2:0]    row_hits, total;
   logic [1:0]    col_idx;
   logic [3:0]    scan_code;
   logic [CW:0]   cnt_inc;

   assign row       = ~(4'b0001 << idx_q);
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

   assign tick      = (tick_cnt_q == TICK_LAST);
   assign scan_done = tick && (idx_q == 2'd3);

   // Closed keys on the row currently driven; col_idx ends on the lowest closed column.
   always_comb begin
      row_hits = 3'd0;
      col_idx  = 2'd0;
      for (int c = 3; c >= 0; c--) begin
         if (!col_s_q[c]) begin
            row_hits = row_hits + 3'd1;
            col_idx  = 2'(c);
         end
      end
   end

   assign total     = {1'b0, nkeys_q} + row_hits;
   assign scan_hit  = scan_done && (total == 3'd1);
   assign scan_code = (nkeys_q == 2'd1) ? code_q : {idx_q, col_idx};
   assign cnt_inc   = {1'b0, cnt_q} + 1'b1;

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      idx_d      = tick ? idx_q + 2'd1 : idx_q;
      nkeys_d    = nkeys_q;
      code_d     = code_q;
      if (tick) begin
         if (idx_q == 2'd3) begin
            nkeys_d = 2'd0;
            code_d  = 4'd0;
         end else begin
            // Count saturates at 2: anything beyond one key is already a reject.
            nkeys_d = (total >= 3'd2) ? 2'd2 : total[1:0];
            if (nkeys_q == 2'd0 && row_hits == 3'd1) code_d = {idx_q, col_idx};
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      if (scan_done) begin
         case (state_q)
            IDLE: begin
               if (scan_hit) begin
                  cand_d = scan_code;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d     = PRESSED;
                     key_d       = scan_code;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                  end else begin
                     state_d = DEBOUNCE;
                     cnt_d   = CW'(1);
                  end
               end
            end
            DEBOUNCE: begin
               if (scan_hit && scan_code == cand_q) begin
                  if (cnt_inc >= CNT_DONE) begin
                     state_d     = PRESSED;
                     key_d       = cand_q;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc[CW-1:0];
                  end
               end else if (scan_hit) begin
                  cand_d = scan_code;
                  cnt_d  = CW'(1);
               end else begin
                  state_d = IDLE;
               end
            end
            PRESSED: begin
               if (!(scan_hit && scan_code == key_q)) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d    = IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = CW'(1);
                  end
               end
            end
            RELEASE: begin
               if (scan_hit && scan_code == key_q) begin
                  state_d = PRESSED;
               end else if (scan_hit) begin
                  cnt_d = '0;
               end else if (cnt_inc >= CNT_DONE) begin
                  state_d    = IDLE;
                  key_down_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc[CW-1:0];
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk0 or negedge rst) begin
      if (!rst) begin
         col_m_q     <= 4'hF;
         col_s_q     <= 4'hF;
         tick_cnt_q  <= '0;
         idx_q       <= 2'd0;
         nkeys_q     <= 2'd0;
         code_q      <= 4'd0;
         state_q     <= IDLE;
         cand_q      <= 4'd0;
         cnt_q       <= '0;
         key_q       <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         col_m_q     <= col;
         col_s_q     <= col_m_q;
         tick_cnt_q  <= tick_cnt_d;
         idx_q       <= idx_d;
         nkeys_q     <= nkeys_d;
         code_q      <= code_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: ideal keypad matrix model, scan-level vector table,
// reset-while-pressed sequence, and random patterns against a scan-history reference.
module tb_keypad_scanner;
   localparam int TICK_DIV = 4;
   localparam int DS       = 2;
   localparam int SCAN     = 4 * TICK_DIV;

   logic       clk0 = 1'b0;
   logic       rst  = 1'b0;
   logic [3:0] col, row, key;
   logic       key_valid, key_down;
   logic [15:0] pressed = 16'h0000;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] pat;
      logic        ev;
      logic        ed;
      logic [3:0]  ek;
   } vec_t;
   vec_t vecs[$];

   int         hist[$];
   logic       m_down;
   logic [3:0] m_key;

   keypad_scanner #(.TICK_DIV(TICK_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk0(clk0), .rst(rst), .col(col), .row(row),
      .key(key), .key_valid(key_valid), .key_down(key_down)
   );

   always #5 clk0 = ~clk0;

   // Pressed key at (r,c) pulls column c low while row r is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row[r])
            for (int c = 0; c < 4; c++)
               if (pressed[r*4 + c]) col[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] pat, input logic ev, input logic ed, input logic [3:0] ek);
      vec_t v;
      v.pat = pat; v.ev = ev; v.ed = ed; v.ek = ek;
      vecs.push_back(v);
   endtask

   // One full scan with a fixed key pattern; starts and ends on a negedge aligned to row 0.
   task automatic run_scan(input logic [15:0] pat, input logic ev, input logic ed,
                           input logic [3:0] ek, input string tag);
      logic [3:0] exp_row;
      pressed = pat;
      for (int i = 0; i < SCAN; i++) begin
         @(posedge clk0);
         @(negedge clk0);
         exp_row = ~(4'b0001 << (((i + 1) / TICK_DIV) % 4));
         check({tag, " row"}, {28'd0, row}, {28'd0, exp_row});
         if (i == SCAN - 1) begin
            check({tag, " key_valid"}, {31'd0, key_valid}, {31'd0, ev});
            check({tag, " key_down"},  {31'd0, key_down},  {31'd0, ed});
            check({tag, " key"},       {28'd0, key},       {28'd0, ek});
         end else begin
            check({tag, " key_valid idle"}, {31'd0, key_valid}, 32'd0);
         end
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_down = 1'b0;
      m_key  = 4'd0;
   endtask

   // Reference: press accepted when the last DS scans all saw the same single key;
   // release when enough empty scans follow the last scan that saw the held key.
   task automatic model_scan(input logic [15:0] pat, output logic ev);
      int res, last, cnt;
      logic same;
      res = -1;
      if ($countones(pat) == 1)
         for (int b = 0; b < 16; b++) if (pat[b]) res = b;
      hist.push_back(res);
      ev = 1'b0;
      if (!m_down) begin
         if (res >= 0 && hist.size() >= DS) begin
            same = 1'b1;
            for (int j = hist.size() - DS; j < hist.size(); j++)
               if (hist[j] != res) same = 1'b0;
            if (same) begin
               ev = 1'b1;
               m_down = 1'b1;
               m_key = res[3:0];
            end
         end
      end else begin
         last = -1;
         for (int j = 0; j < hist.size(); j++) if (hist[j] == int'(m_key)) last = j;
         cnt = 0;
         for (int j = last + 1; j < hist.size(); j++)
            cnt = (j == last + 1) ? 1 : ((hist[j] < 0) ? cnt + 1 : 0);
         if (cnt >= DS) m_down = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk0);
      rst = 1'b0;
      repeat (3) @(negedge clk0);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pat, prev;
      logic        ev;
      int          r;

      add(16'h0000, 0, 0, 4'h0); add(16'h0000, 0, 0, 4'h0);
      add(16'h0200, 0, 0, 4'h0); add(16'h0200, 1, 1, 4'h9);
      for (int i = 0; i < 8; i++) add(16'h0200, 0, 1, 4'h9);
      add(16'h0000, 0, 1, 4'h9); add(16'h0000, 0, 0, 4'h9); add(16'h0000, 0, 0, 4'h9);
      add(16'h0200, 0, 0, 4'h9); add(16'h0000, 0, 0, 4'h9);
      add(16'h0200, 0, 0, 4'h9); add(16'h0200, 1, 1, 4'h9);
      add(16'h0000, 0, 1, 4'h9); add(16'h0000, 0, 0, 4'h9);
      add(16'h0021, 0, 0, 4'h9); add(16'h0021, 0, 0, 4'h9);
      add(16'h0001, 0, 0, 4'h9); add(16'h0001, 1, 1, 4'h0);
      add(16'h0000, 0, 1, 4'h0); add(16'h0000, 0, 0, 4'h0);
      add(16'h0020, 0, 0, 4'h0); add(16'h0020, 1, 1, 4'h5);
      add(16'h0040, 0, 1, 4'h5); add(16'h0040, 0, 1, 4'h5);
      add(16'h0000, 0, 1, 4'h5); add(16'h0000, 0, 0, 4'h5);
      add(16'h0020, 0, 0, 4'h5); add(16'h0020, 1, 1, 4'h5);
      add(16'h0000, 0, 1, 4'h5); add(16'h0020, 0, 1, 4'h5);
      add(16'h0000, 0, 1, 4'h5); add(16'h0000, 0, 0, 4'h5);
      add(16'h3000, 0, 0, 4'h5); add(16'h3000, 0, 0, 4'h5);
      add(16'h8000, 0, 0, 4'h5); add(16'h8000, 1, 1, 4'hF);

      repeat (3) @(negedge clk0);
      check("reset row",       {28'd0, row}, 32'hE);
      check("reset key",       {28'd0, key}, 32'h0);
      check("reset key_valid", {31'd0, key_valid}, 32'd0);
      check("reset key_down",  {31'd0, key_down},  32'd0);
      rst = 1'b1;

      for (int v = 0; v < vecs.size(); v++)
         run_scan(vecs[v].pat, vecs[v].ev, vecs[v].ed, vecs[v].ek, $sformatf("vec%0d", v));

      // Reset while key 15 is pressed and still held.
      repeat (5) @(negedge clk0);
      rst = 1'b0;
      #1;
      check("midrst row",       {28'd0, row}, 32'hE);
      check("midrst key",       {28'd0, key}, 32'h0);
      check("midrst key_down",  {31'd0, key_down},  32'd0);
      check("midrst key_valid", {31'd0, key_valid}, 32'd0);
      repeat (3) @(negedge clk0);
      rst = 1'b1;
      run_scan(16'h8000, 0, 0, 4'h0, "held1");
      run_scan(16'h8000, 1, 1, 4'hF, "held2");

      do_reset();
      model_reset();
      prev = 16'h0000;
      for (int s = 0; s < 80; s++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      pat = prev;
         else if (r < 55) pat = 16'h0000;
         else if (r < 85) pat = 16'(1) << $urandom_range(0, 15);
         else             pat = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
         prev = pat;
         model_scan(pat, ev);
         run_scan(pat, ev, m_down, m_key, $sformatf("rnd%0d", s));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
